// File: rtl/dcs_out_quant.sv
// Collects 8 x 32-bit result words, normalizes them by a per-frame shift and
// streams 8 quantized bytes. Optional rounding quantizer: DCS_OUT_ROUND_EN.
module dcs_out_quant (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [4:0]  out_shift,
  output logic        out_last,
  output logic        busy,
  output logic        err_ovf
);

  typedef enum logic [1:0] {COLLECT, NORM, EMIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] wbuf_q [8];
  logic [31:0] wbuf_d [8];
  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  ecnt_q, ecnt_d;
  logic [31:0] max_q, max_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [4:0]  out_shift_q, out_shift_d;
  logic        out_last_q, out_last_d;
  logic        err_ovf_q, err_ovf_d;
  logic [4:0]  shift_calc;

  function automatic logic [7:0] quant(input logic [31:0] w, input logic [4:0] s);
`ifdef DCS_OUT_ROUND_EN
    logic [32:0] sum;
    if (s == 5'd0) return w[7:0];
    // 33-bit add so a near-full word cannot wrap before the shift.
    sum = {1'b0, w} + (33'd1 << (s - 5'd1));
    return ((sum >> s) > 33'd255) ? 8'hFF : 8'(sum >> s);
`else
    return 8'(w >> s);
`endif
  endfunction

  // Smallest shift that brings the frame maximum into byte range.
  always_comb begin
    shift_calc = 5'd24;
    for (int s = 24; s >= 0; s--) begin
      if ((max_q >> s) <= 32'd255) shift_calc = 5'(s);
    end
  end

  always_comb begin
    // NOTE: every _d gets a default (hold) first so no path leaves it unassigned; that is what keeps always_comb latch-free.
    state_d     = state_q;
    wbuf_d      = wbuf_q;
    wcnt_d      = wcnt_q;
    ecnt_d      = ecnt_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_shift_d = out_shift_q;
    out_last_d  = out_last_q;
    err_ovf_d   = err_ovf_q;

    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          wbuf_d[wcnt_q] = in_data;
          wcnt_d         = wcnt_q + 3'd1;
          if (in_data > max_q) max_d = in_data;
          if (wcnt_q == 3'd7) state_d = NORM;
        end
      end
      NORM: begin
        out_shift_d = shift_calc;
        out_data_d  = quant(wbuf_q[0], shift_calc);
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        ecnt_d      = 3'd0;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (ecnt_q == 3'd7) begin
            state_d     = COLLECT;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            wcnt_d      = 3'd0;
            ecnt_d      = 3'd0;
            max_d       = 32'd0;
          end else begin
            ecnt_d     = ecnt_q + 3'd1;
            out_data_d = quant(wbuf_q[ecnt_d], out_shift_q);
            out_last_d = (ecnt_d == 3'd7);
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // No backpressure upstream: words arriving outside COLLECT are lost.
    if (in_valid && state_q != COLLECT) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      // NOTE: the frame buffer is cleared on reset too, so a discarded frame can never leak into the next one.
      for (int i = 0; i < 8; i++) wbuf_q[i] <= 32'd0;
      wcnt_q      <= 3'd0;
      ecnt_q      <= 3'd0;
      max_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_shift_q <= 5'd0;
      out_last_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge _d values regardless of statement order.
      state_q     <= state_d;
      wbuf_q      <= wbuf_d;
      wcnt_q      <= wcnt_d;
      ecnt_q      <= ecnt_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_shift_q <= out_shift_d;
      out_last_q  <= out_last_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shift = out_shift_q;
  assign out_last  = out_last_q;
  assign err_ovf   = err_ovf_q;
  assign busy      = (state_q != COLLECT);

endmodule

// File: tb/tb_dcs_out_quant.sv
// Directed self-checking bench for dcs_out_quant; expected bytes hand-computed
// (rounding-build values selected with DCS_OUT_ROUND_EN).
module tb_dcs_out_quant;

  typedef logic [31:0] frame_t [8];
  typedef logic [7:0]  bytes_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [4:0]  out_shift;
  logic        out_last;
  logic        busy;
  logic        err_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  dcs_out_quant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_last  (out_last),
    .busy      (busy),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Feeds 8 words back to back, then checks the NORM gap and the 2-cycle latency.
  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("norm_valid", {31'd0, out_valid}, 32'd0);
    check("norm_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
  endtask

  // Drains one frame; toggle selects the 1,0,0 out_ready pattern.
  task automatic drain(input bytes_t exp, input logic [4:0] exp_shift, input bit toggle, input string tag);
    int          n = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [7:0]  prev_data = 8'd0;
    logic        prev_last = 1'b0;
    while (n < 8 && cyc < 100) begin
      if (!out_valid) begin
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        break;
      end
      if (stalled) begin
        check({tag, "_hold_data"}, {24'd0, out_data}, {24'd0, prev_data});
        check({tag, "_hold_last"}, {31'd0, out_last}, {31'd0, prev_last});
      end
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (out_ready) begin
        check($sformatf("%s_byte%0d", tag, n), {24'd0, out_data}, {24'd0, exp[n]});
        check($sformatf("%s_last%0d", tag, n), {31'd0, out_last}, {31'd0, (n == 7)});
        check($sformatf("%s_shift%0d", tag, n), {27'd0, out_shift}, {27'd0, exp_shift});
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_count"}, n, 8);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_data"}, {24'd0, out_data}, {24'd0, exp[7]});
    check({tag, "_idle_shift"}, {27'd0, out_shift}, {27'd0, exp_shift});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_shift"}, {27'd0, out_shift}, 32'd0);
    check({tag, "_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err_ovf}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t f;
    bytes_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Small-max frame passes through unchanged.
    f = '{0, 10, 20, 30, 40, 50, 60, 255};
    e = '{0, 10, 20, 30, 40, 50, 60, 255};
    send_frame(f);
    drain(e, 5'd0, 1'b0, "pass");

    f = '{1000, 0, 0, 0, 0, 0, 0, 0};
    e = '{250, 0, 0, 0, 0, 0, 0, 0};
    send_frame(f);
    drain(e, 5'd2, 1'b0, "k1000");

    f = '{1022, 2, 0, 0, 0, 0, 0, 0};
`ifdef DCS_OUT_ROUND_EN
    e = '{255, 1, 0, 0, 0, 0, 0, 0};
`else
    e = '{255, 0, 0, 0, 0, 0, 0, 0};
`endif
    send_frame(f);
    drain(e, 5'd2, 1'b0, "k1022");

    f = '{32'hFFFF_FFFF, 32'h0080_0000, 0, 0, 0, 0, 0, 0};
`ifdef DCS_OUT_ROUND_EN
    e = '{255, 1, 0, 0, 0, 0, 0, 0};
`else
    e = '{255, 0, 0, 0, 0, 0, 0, 0};
`endif
    send_frame(f);
    drain(e, 5'd24, 1'b0, "full");

    f = '{0, 0, 0, 0, 0, 0, 0, 0};
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(f);
    drain(e, 5'd0, 1'b0, "zero");

    // Stalls: out_ready 1,0,0,1,0,0,...
    f = '{3, 1, 4, 1, 5, 9, 2, 6};
    e = '{3, 1, 4, 1, 5, 9, 2, 6};
    send_frame(f);
    drain(e, 5'd0, 1'b1, "stall");

    // A word arriving during EMIT is dropped and flagged; the frame is untouched.
    f = '{8, 7, 6, 5, 4, 3, 2, 1};
    e = '{8, 7, 6, 5, 4, 3, 2, 1};
    send_frame(f);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_err", {31'd0, err_ovf}, 32'd1);
    check("ovf_data", {24'd0, out_data}, 32'd8);
    drain(e, 5'd0, 1'b0, "ovf");
    check("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Reset mid-EMIT with a byte pending.
    f = '{300, 300, 300, 300, 300, 300, 300, 300};
    send_frame(f);
    check("mid_shift", {27'd0, out_shift}, 32'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("mid_pending", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_reset");

    // Partial frame discarded by reset in COLLECT.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd1000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    f = '{5, 5, 5, 5, 5, 5, 5, 5};
    e = '{5, 5, 5, 5, 5, 5, 5, 5};
    send_frame(f);
    drain(e, 5'd0, 1'b0, "fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
